// File: rtl/edge_pkg.sv
// Shared constants and FSM state encoding for the edge-detect frame writer.
`timescale 1ns/1ps
package edge_pkg;

  localparam int IMG_WIDTH    = 640;
  localparam int IMG_HEIGHT   = 480;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/pix_word_fifo.sv
// Show-ahead synchronous FIFO holding {address, packed word} entries.
`timescale 1ns/1ps
module pix_word_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_one
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_count;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_count   = r_wr - r_rd;
  assign o_one     = (w_count == (AW+1)'(1));
  assign o_dout    = r_mem[r_rd[AW-1:0]];
  // A push on a full FIFO is still taken when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage array, write side only.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/edge_frame_writer.sv
// Captures one edge-detect frame, packs 4 pixels per word and writes the
// words to the frame buffer through a small FIFO and a req/ack port.
`timescale 1ns/1ps
module edge_frame_writer #(
  parameter int IMG_WIDTH  = edge_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = edge_pkg::IMG_HEIGHT,
  parameter int ADDR_W     = 17,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              pix_valid,
  input  logic [12:0]       pix_row,
  input  logic [12:0]       pix_col,
  input  logic [7:0]        pix_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              frame_done,
  output logic              seq_err,
  output logic              ovf_err,
  output logic [31:0]       frame_cycles
);

  import edge_pkg::*;

  localparam int FW = ADDR_W + 32;

  state_t            r_state;
  state_t            w_next;
  logic              w_sof;
  logic              w_accept;
  logic              w_at_end;
  logic              w_last;
  logic              w_pop;
  logic              w_drop;
  logic              w_drained;
  logic              w_empty;
  logic              w_full;
  logic              w_one;
  logic [FW-1:0]     w_head;

  logic [12:0]       r_exp_col;
  logic [12:0]       r_exp_row;
  logic [1:0]        r_lane;
  logic [23:0]       r_pack;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_word_addr;
  logic              r_word_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_seq_err;
  logic              r_ovf_err;
  logic [31:0]       r_cycles;

  assign w_sof    = pix_valid && (pix_row == '0) && (pix_col == '0);
  assign w_accept = pix_valid && ((r_state == WAIT_SOF && w_sof) || r_state == CAPTURE);
  assign w_at_end = (r_exp_row == 13'(IMG_HEIGHT - 1)) && (r_exp_col == 13'(IMG_WIDTH - 1));
  assign w_last   = (r_state == CAPTURE) && w_accept && w_at_end;
  assign w_pop    = !w_empty && wr_ack;
  assign w_drop   = r_word_valid && w_full && !w_pop;
  // Drain completes on the cycle the final word is acked, so frame_done
  // follows that ack directly instead of waiting for the FIFO to show empty.
  assign w_drained = !r_word_valid && (w_empty || (w_one && w_pop));

  pix_word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_word_valid),
    .i_din   ({r_word_addr, r_word}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_one   (w_one)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (arm)       w_next = WAIT_SOF;
      WAIT_SOF: if (w_sof)     w_next = CAPTURE;
      CAPTURE:  if (w_last)    w_next = DRAIN;
      DRAIN:    if (w_drained) w_next = DONE;
      DONE:                    w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // FSM and write-port outputs.
  always_comb begin
    busy       = (r_state == WAIT_SOF) || (r_state == CAPTURE) || (r_state == DRAIN);
    frame_done = (r_state == DONE);
    wr_req     = !w_empty;
    wr_addr    = w_empty ? '0 : w_head[FW-1:32];
    wr_data    = w_empty ? '0 : w_head[31:0];
  end

  assign seq_err      = r_seq_err;
  assign ovf_err      = r_ovf_err;
  assign frame_cycles = r_cycles;

  // Position counters and packer; address comes from the counters, not the tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_col    <= '0;
      r_exp_row    <= '0;
      r_lane       <= '0;
      r_pack       <= '0;
      r_word       <= '0;
      r_word_addr  <= '0;
      r_word_valid <= 1'b0;
      r_addr       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (r_state == IDLE && arm) begin
        r_exp_col <= '0;
        r_exp_row <= '0;
        r_lane    <= '0;
        r_addr    <= ADDR_W'(BASE_ADDR);
      end else if (w_accept) begin
        if (r_exp_col == 13'(IMG_WIDTH - 1)) begin
          r_exp_col <= '0;
          r_exp_row <= r_exp_row + 1'b1;
        end else begin
          r_exp_col <= r_exp_col + 1'b1;
        end
        if (r_lane == 2'(PIX_PER_WORD - 1)) begin
          r_word       <= {pix_data, r_pack};
          r_word_addr  <= r_addr;
          r_word_valid <= 1'b1;
          r_addr       <= r_addr + 1'b1;
        end else begin
          case (r_lane)
            2'd0:    r_pack[7:0]   <= pix_data;
            2'd1:    r_pack[15:8]  <= pix_data;
            default: r_pack[23:16] <= pix_data;
          endcase
        end
        r_lane <= r_lane + 1'b1;
      end
    end
  end

  // Sticky error flags and saturating frame cycle counter, cleared at SOF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq_err <= 1'b0;
      r_ovf_err <= 1'b0;
      r_cycles  <= '0;
    end else if (r_state == WAIT_SOF && w_sof) begin
      r_seq_err <= 1'b0;
      r_ovf_err <= 1'b0;
      r_cycles  <= 32'd1;
    end else begin
      if (r_state == CAPTURE && w_accept &&
          (pix_row != r_exp_row || pix_col != r_exp_col))
        r_seq_err <= 1'b1;
      if (w_drop)
        r_ovf_err <= 1'b1;
      if ((r_state == CAPTURE || r_state == DRAIN) && r_cycles != '1)
        r_cycles <= r_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Scoreboard bench for edge_frame_writer on an 8x2 frame, base 16, 2-deep FIFO.
`timescale 1ns/1ps
module tb_edge_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        pix_valid;
  logic [12:0] pix_row;
  logic [12:0] pix_col;
  logic [7:0]  pix_data;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        busy;
  logic        frame_done;
  logic        seq_err;
  logic        ovf_err;
  logic [31:0] frame_cycles;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [48:0] sb_q[$];
  logic [48:0] sb_e;
  int          done_cnt = 0;
  logic [31:0] done_cycles = '0;
  bit          ack_toggle = 1'b0;

  edge_frame_writer #(
    .IMG_WIDTH  (8),
    .IMG_HEIGHT (2),
    .ADDR_W     (17),
    .BASE_ADDR  (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .pix_valid    (pix_valid),
    .pix_row      (pix_row),
    .pix_col      (pix_col),
    .pix_data     (pix_data),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .busy         (busy),
    .frame_done   (frame_done),
    .seq_err      (seq_err),
    .ovf_err      (ovf_err),
    .frame_cycles (frame_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every accepted write is popped from the scoreboard.
  always @(negedge clk) begin
    if (!rst && wr_req && wr_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wr", 64'(wr_addr), 64'h1_FFFF);
      end else begin
        sb_e = sb_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(sb_e[48:32]));
        chk("wr_data", 64'(wr_data), 64'(sb_e[31:0]));
      end
    end
    if (!rst && frame_done) begin
      done_cnt++;
      done_cycles = frame_cycles;
    end
  end

  always @(posedge clk) begin
    if (ack_toggle) begin
      #1 wr_ack = ~wr_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drives the 16 pixels of a frame back to back and pushes expected words.
  task automatic send_frame(input bit swap56, input int stop_at, input bit [3:0] keep,
                            input bit arm_mid, input logic [7:0] off);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == stop_at) begin
        pix_valid = 1'b0;
        return;
      end
      pix_valid = 1'b1;
      pix_row   = 13'(i / 8);
      pix_col   = 13'(i % 8);
      if (swap56 && i == 5) pix_col = 13'd6;
      if (swap56 && i == 6) pix_col = 13'd5;
      pix_data  = off + 8'(i);
      w[8*(i%4) +: 8] = pix_data;
      if ((i % 4) == 3 && keep[i/4]) sb_q.push_back({17'(16 + i/4), w});
      arm = arm_mid && (i == 10);
      tick();
    end
    pix_valid = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    if (!frame_done) chk("done_timeout", 64'(frame_done), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; pix_valid = 1'b0; pix_row = '0; pix_col = '0;
    pix_data = '0; wr_ack = 1'b0;
    tick(); tick();
    chk("rst_wr_req", 64'(wr_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cycles", 64'(frame_cycles), 64'd0);
    rst = 1'b0;
    tick();

    // 1: ordered frame, ack tied high
    wr_ack = 1'b1;
    do_arm();
    send_frame(1'b0, -1, 4'hF, 1'b0, 8'h00);
    wait_done(50);
    tick();
    chk("s1_cycles", 64'(done_cycles), 64'd18);
    chk("s1_done_cnt", 64'(done_cnt), 64'd1);
    chk("s1_seq", 64'(seq_err), 64'd0);
    chk("s1_ovf", 64'(ovf_err), 64'd0);
    chk("s1_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("s1_busy", 64'(busy), 64'd0);
    chk("s1_done_pulse", 64'(frame_done), 64'd0);

    // 2: non-SOF pixel in WAIT_SOF is discarded
    do_arm();
    chk("s2_busy_arm", 64'(busy), 64'd1);
    pix_valid = 1'b1; pix_row = 13'd1; pix_col = 13'd3; pix_data = 8'hAA;
    tick();
    send_frame(1'b0, -1, 4'hF, 1'b0, 8'h20);
    wait_done(50);
    chk("s2_cycles", 64'(done_cycles), 64'd18);
    chk("s2_seq", 64'(seq_err), 64'd0);
    chk("s2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 3: swapped tags on pixels 5 and 6
    do_arm();
    send_frame(1'b1, -1, 4'hF, 1'b0, 8'h00);
    wait_done(50);
    chk("s3_seq", 64'(seq_err), 64'd1);
    chk("s3_sb_empty", 64'(sb_q.size()), 64'd0);

    // 4: ack held low, words 3 and 4 overflow
    wr_ack = 1'b0;
    do_arm();
    send_frame(1'b0, -1, 4'b0011, 1'b0, 8'h40);
    repeat (4) tick();
    chk("s4_ovf_mid", 64'(ovf_err), 64'd1);
    chk("s4_seq_cleared", 64'(seq_err), 64'd0);
    chk("s4_busy_mid", 64'(busy), 64'd1);
    chk("s4_no_done", 64'(done_cnt), 64'd3);
    wr_ack = 1'b1;
    wait_done(50);
    chk("s4_done_cnt", 64'(done_cnt), 64'd4);
    chk("s4_ovf", 64'(ovf_err), 64'd1);
    chk("s4_sb_empty", 64'(sb_q.size()), 64'd0);

    // 5: reset at pixel 9, then a clean frame
    do_arm();
    send_frame(1'b0, 9, 4'hF, 1'b0, 8'h60);
    chk("s5_pre_req", 64'(wr_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("s5_rst_req", 64'(wr_req), 64'd0);
    chk("s5_rst_addr", 64'(wr_addr), 64'd0);
    chk("s5_rst_data", 64'(wr_data), 64'd0);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    chk("s5_rst_done", 64'(frame_done), 64'd0);
    chk("s5_rst_err", 64'({seq_err, ovf_err}), 64'd0);
    chk("s5_rst_cycles", 64'(frame_cycles), 64'd0);
    chk("s5_pending", 64'(sb_q.size()), 64'd1);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    do_arm();
    send_frame(1'b0, -1, 4'hF, 1'b0, 8'h00);
    wait_done(50);
    chk("s5_cycles", 64'(done_cycles), 64'd18);
    chk("s5_err", 64'({seq_err, ovf_err}), 64'd0);
    chk("s5_sb_empty", 64'(sb_q.size()), 64'd0);

    // 6: arm during CAPTURE and DRAIN ignored, ack toggling
    done_cnt   = 0;
    wr_ack     = 1'b1;
    ack_toggle = 1'b1;
    do_arm();
    send_frame(1'b0, -1, 4'hF, 1'b1, 8'h80);
    do_arm();
    wait_done(60);
    ack_toggle = 1'b0;
    tick();
    wr_ack = 1'b1;
    repeat (3) tick();
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_done_cnt", 64'(done_cnt), 64'd1);
    chk("s6_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("s6_err", 64'({seq_err, ovf_err}), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
